// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams and UART transmitter handshake shared by uart_tx_arbiter.
// master = arbiter side, slave = requesters plus transmitter.
interface uart_tx_arbiter_if #(parameter int NUM_REQ = 4);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   grant;
  logic [7:0]           tx_data;
  logic                 tx_start;
  logic                 tx_busy;
  logic                 err_timeout;

  modport master (input  req_valid, req_data, req_last, tx_busy,
                  output req_ready, grant, tx_data, tx_start, err_timeout);
  modport slave  (output req_valid, req_data, req_last, tx_busy,
                  input  req_ready, grant, tx_data, tx_start, err_timeout);
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked sharing of one UART transmitter among NUM_REQ byte streams.
// Optional busy-rise watchdog: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 64
) (
  input  logic              CLK,
  input  logic              RESET,
  uart_tx_arbiter_if.master bus
);
  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO} state_t;

  if (NUM_REQ < 2 || NUM_REQ > 8 || BUSY_TIMEOUT < 1) begin : g_bad_cfg
    $error("uart_tx_arbiter: unsupported NUM_REQ/BUSY_TIMEOUT");
  end

  state_t                  state, state_nxt;
  logic [NUM_REQ-1:0]      grant, grant_nxt;
  logic [PTR_W-1:0]        g_idx, g_idx_nxt;
  logic [PTR_W-1:0]        rr_ptr, rr_ptr_nxt;
  logic [7:0]              tx_data, tx_data_nxt;
  logic                    tx_start, tx_start_nxt;
  logic                    last_r, last_r_nxt;
  logic                    to_expired;
  logic                    win_found;
  logic [PTR_W-1:0]        win_idx, cand;
  logic                    xfer;
  logic [NUM_REQ-1:0][7:0] req_byte;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign req_byte[i] = bus.req_data[8*i +: 8];
  end

  // First valid requester strictly after the last packet owner, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!win_found && bus.req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign xfer          = (state == ISSUE) && bus.req_valid[g_idx];
  assign bus.req_ready = (state == ISSUE && !RESET) ? (bus.req_valid & grant) : '0;
  assign bus.grant     = grant;
  assign bus.tx_data   = tx_data;
  assign bus.tx_start  = tx_start;

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    g_idx_nxt    = g_idx;
    rr_ptr_nxt   = rr_ptr;
    tx_data_nxt  = tx_data;
    tx_start_nxt = 1'b0;
    last_r_nxt   = last_r;
    unique case (state)
      IDLE: begin
        // busy may still be high from a byte launched before reset
        if (win_found && !bus.tx_busy) begin
          grant_nxt = NUM_REQ'(1) << win_idx;
          g_idx_nxt = win_idx;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (xfer) begin
          tx_data_nxt  = req_byte[g_idx];
          tx_start_nxt = 1'b1;
          last_r_nxt   = bus.req_last[g_idx];
          state_nxt    = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (bus.tx_busy) begin
          state_nxt = WAIT_LO;
        end else if (to_expired) begin
          grant_nxt  = '0;
          rr_ptr_nxt = g_idx;
          state_nxt  = IDLE;
        end
      end
      WAIT_LO: begin
        if (!bus.tx_busy) begin
          if (last_r) begin
            grant_nxt  = '0;
            rr_ptr_nxt = g_idx;
            state_nxt  = IDLE;
          end else begin
            state_nxt  = ISSUE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      grant    <= '0;
      g_idx    <= '0;
      rr_ptr   <= PTR_W'(NUM_REQ - 1);
      tx_data  <= '0;
      tx_start <= 1'b0;
      last_r   <= 1'b0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      g_idx    <= g_idx_nxt;
      rr_ptr   <= rr_ptr_nxt;
      tx_data  <= tx_data_nxt;
      tx_start <= tx_start_nxt;
      last_r   <= last_r_nxt;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(BUSY_TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt;
  logic            err_r;

  // Counts WAIT_HI cycles; the last one without busy drops the packet.
  assign to_expired      = (to_cnt == TO_W'(BUSY_TIMEOUT - 1));
  assign bus.err_timeout = err_r;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      to_cnt <= '0;
      err_r  <= 1'b0;
    end else begin
      to_cnt <= (state == WAIT_HI && !bus.tx_busy) ? to_cnt + 1'b1 : '0;
      if (state == WAIT_HI && !bus.tx_busy && to_expired) err_r <= 1'b1;
    end
  end
`else
  assign to_expired      = 1'b0;
  assign bus.err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: per-requester byte queues, a UART busy model,
// and a round-robin/packet-level scoreboard checked every cycle on the falling edge.
module tb_uart_tx_arbiter;
  localparam int N = 4;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();
  uart_tx_arbiter #(.NUM_REQ(N), .BUSY_TIMEOUT(64)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));

  always #20 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // requester byte stores: {last, data}
  logic [8:0]   mem [N][256];
  int           head [N];
  int           tail [N];
  int           hold [N];
  int           p_valid   = 100;
  int           ulen_min  = 4;
  int           ulen_max  = 30;
  bit           uart_dead = 1'b0;
  logic [N-1:0] acc = '0;
  logic [7:0]   txq [$];
  int           sent_req [$];
  logic [7:0]   sent_dat [$];

  function automatic logic [N-1:0] pick(input logic [N-1:0] v, input int p);
    for (int k = 1; k <= N; k++)
      if (v[(p + k) % N]) return N'(1) << ((p + k) % N);
    return '0;
  endfunction

  function automatic int oh2i(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return -1;
  endfunction

  // requester drivers: present queue heads, optionally gated by random/held valid
  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    for (int i = 0; i < N; i++) begin
      head[i] = 0; tail[i] = 0; hold[i] = 0;
      for (int j = 0; j < 256; j++) mem[i][j] = '0;
    end
    forever begin
      @(posedge CLK); #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) head[i]++;
        if (hold[i] > 0) hold[i]--;
        bus.req_valid[i] = (head[i] < tail[i]) && (hold[i] == 0) && ($urandom_range(99) < p_valid);
        bus.req_data[8*i +: 8] = mem[i][head[i] % 256][7:0];
        bus.req_last[i]        = mem[i][head[i] % 256][8];
      end
    end
  end

  // UART model: busy rises two edges after the edge that samples tx_start
  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge CLK);
      if (bus.tx_start === 1'b1 && !uart_dead) begin
        repeat (3) @(posedge CLK);
        #1 bus.tx_busy = 1'b1;
        repeat ($urandom_range(ulen_max, ulen_min)) @(posedge CLK);
        #1 bus.tx_busy = 1'b0;
      end
    end
  end

  // scoreboard
  logic [N-1:0] gnt_q  = '0;
  logic [N-1:0] vld_q  = '0;
  bit           busy_q = 1'b0;
  bit           rst_q  = 1'b1;
  bit           xfer_q = 1'b0;
  bit           last_q = 1'b0;
  int           m_rr   = N - 1;
  int           m_own  = -1;

  always @(negedge CLK) begin : mon
    logic [N-1:0] xfer;
    if (rst_q) begin
      chk("rst_grant", bus.grant, 0);
      chk("rst_start", bus.tx_start, 0);
      chk("rst_data", bus.tx_data, 0);
      chk("rst_err", bus.err_timeout, 0);
      m_rr  = N - 1;
      m_own = -1;
      txq.delete();
    end else begin
      chk("start_lat", bus.tx_start, xfer_q);
      chk("start_busy", bus.tx_start & bus.tx_busy, 0);
      if (bus.tx_start === 1'b1 && txq.size() > 0) begin
        chk("tx_data", bus.tx_data, txq.pop_front());
        sent_req.push_back(m_own);
        sent_dat.push_back(bus.tx_data);
      end
      chk("gnt_onehot", $onehot0(bus.grant), 1);
      chk("rdy_mask", bus.req_ready & ~(bus.grant & bus.req_valid), 0);
      if (gnt_q == 0 && bus.grant != 0) begin
        chk("gnt_busy", busy_q, 0);
        chk("rr_win", bus.grant, pick(vld_q, m_rr));
        m_own = oh2i(bus.grant);
        if ((bus.req_valid & bus.grant) != 0) chk("rdy_first", bus.req_ready, bus.grant);
      end else if (gnt_q != 0 && bus.grant != 0) begin
        chk("gnt_hold", bus.grant, gnt_q);
      end else if (gnt_q != 0 && bus.grant == 0) begin
        if (bus.err_timeout !== 1'b1) chk("pkt_end", last_q, 1);
        m_rr = m_own;
      end
    end
    if (RESET) chk("rst_ready", bus.req_ready, 0);
    xfer = bus.req_ready & bus.req_valid;
    for (int i = 0; i < N; i++)
      if (xfer[i]) begin
        txq.push_back(mem[i][head[i] % 256][7:0]);
        last_q = mem[i][head[i] % 256][8];
      end
    acc    = xfer;
    xfer_q = |xfer;
    gnt_q  = bus.grant;
    vld_q  = bus.req_valid;
    busy_q = bus.tx_busy;
    rst_q  = RESET;
  end

  task automatic push_byte(input int r, input bit last, input logic [7:0] d);
    mem[r][tail[r] % 256] = {last, d};
    tail[r]++;
  endtask

  task automatic push_pkt(input int r, input int len);
    for (int b = 0; b < len; b++) push_byte(r, b == len - 1, 8'($urandom));
  endtask

  task automatic do_reset(input int cyc);
    @(posedge CLK); #1 RESET = 1'b1;
    repeat (cyc) @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
  endtask

  task automatic sent_clear();
    sent_req.delete();
    sent_dat.delete();
  endtask

  task automatic wait_idle(input int budget);
    bit done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge CLK);
      done = (bus.grant == 0) && !bus.tx_busy && (txq.size() == 0);
      for (int i = 0; i < N; i++) if (head[i] < tail[i]) done = 1'b0;
    end
    chk("idle_wait", done, 1);
  endtask

  task automatic wait_gnt(input logic [N-1:0] g, input int budget);
    for (int c = 0; c < budget && bus.grant != g; c++) @(negedge CLK);
    chk("gnt_wait", bus.grant, g);
  endtask

  task automatic chk_order(input string tag, input int exp_req []);
    chk({tag, "_n"}, sent_req.size(), exp_req.size());
    for (int i = 0; i < exp_req.size() && i < sent_req.size(); i++)
      chk({tag, "_req"}, sent_req[i], exp_req[i]);
  endtask

  initial begin
    int pushed;
    bit seen;
    repeat (4) @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);

    // single packet from requester 2
    sent_clear();
    push_byte(2, 1'b0, 8'h55);
    push_byte(2, 1'b1, 8'hA3);
    wait_gnt(4'b0100, 50);
    wait_idle(2000);
    chk("t1_n", sent_req.size(), 2);
    if (sent_req.size() == 2) begin
      chk("t1_d0", sent_dat[0], 8'h55);
      chk("t1_d1", sent_dat[1], 8'hA3);
      chk("t1_r1", sent_req[1], 2);
    end

    // simultaneous contention after reset, two rounds
    do_reset(3);
    for (int round = 0; round < 2; round++) begin
      sent_clear();
      for (int r = 0; r < N; r++) push_pkt(r, 1);
      wait_idle(3000);
      chk_order("t2", '{0, 1, 2, 3});
    end

    // packet lock while the owner stalls
    sent_clear();
    push_pkt(1, 3);
    wait_gnt(4'b0010, 50);
    push_pkt(0, 1);
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge CLK);
      seen = acc[1];
    end
    chk("t3_first", seen, 1);
    hold[1] = 500;
    wait_idle(5000);
    chk_order("t3", '{1, 1, 1, 0});

    // reset while a byte is on the line
    sent_clear();
    ulen_min = 80; ulen_max = 80;
    push_pkt(3, 2);
    wait_gnt(4'b1000, 50);
    for (int c = 0; c < 100 && !bus.tx_busy; c++) @(negedge CLK);
    chk("t4_busy", bus.tx_busy, 1);
    push_pkt(0, 1);
    @(posedge CLK); #1 RESET = 1'b1;
    head[3] = tail[3];
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    for (int c = 0; c < 200 && bus.tx_busy; c++) begin
      @(negedge CLK);
      chk("t4_quiet", bus.tx_start, 0);
    end
    wait_gnt(4'b0001, 20);
    wait_idle(3000);
    ulen_min = 4; ulen_max = 30;

    // random traffic
    for (int round = 0; round < 3; round++) begin
      sent_clear();
      pushed  = 0;
      p_valid = $urandom_range(100, 40);
      for (int p = 0; p < 10; p++) begin
        int r   = $urandom_range(N - 1);
        int len = $urandom_range(4, 1);
        push_pkt(r, len);
        pushed += len;
        if ($urandom_range(3) == 0) hold[$urandom_range(N - 1)] = $urandom_range(60);
      end
      wait_idle(20000);
      chk("t5_n", sent_req.size(), pushed);
    end
    p_valid = 100;

`ifdef UART_ARB_TIMEOUT_EN
    uart_dead = 1'b1;
    push_pkt(2, 2);
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge CLK);
      seen = bus.tx_start;
    end
    chk("to_start", seen, 1);
    hold[2] = 1000;
    repeat (63) @(negedge CLK);
    chk("to_early", bus.err_timeout, 0);
    @(negedge CLK);
    chk("to_flag", bus.err_timeout, 1);
    chk("to_drop", bus.grant, 0);
    head[2]   = tail[2];
    uart_dead = 1'b0;
    repeat (20) @(negedge CLK);
    chk("to_sticky", bus.err_timeout, 1);
    do_reset(2);
    chk("to_clear", bus.err_timeout, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
